// File: rtl/mac_share_if.sv
// Requester-side bus for the shared MAC arbiter: per-requester operand handshakes plus the tagged result.
// ack_o[k] is a same-cycle combinational reply to req_i[k]; a pair transfers on any clock edge where both are high.
interface mac_share_if #(
    parameter int N_REQ     = 4,
    parameter int A_WIDTH   = 24,
    parameter int B_WIDTH   = 24,
    parameter int ACC_WIDTH = 56
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]         req_i;
    logic [N_REQ-1:0]         last_i;
    logic [N_REQ*A_WIDTH-1:0] a_i;
    logic [N_REQ*B_WIDTH-1:0] b_i;
    logic [N_REQ-1:0]         ack_o;
    logic [N_REQ-1:0]         grant_o;
    logic                     busy_o;
    logic [ACC_WIDTH-1:0]     result_o;
    logic [IW-1:0]            result_id_o;
    logic                     result_valid_o;
    logic                     fsm_state;

    modport master (
        output req_i, last_i, a_i, b_i,
        input  ack_o, grant_o, busy_o, result_o, result_id_o, result_valid_o, fsm_state
    );

    modport slave (
        input  req_i, last_i, a_i, b_i,
        output ack_o, grant_o, busy_o, result_o, result_id_o, result_valid_o, fsm_state
    );
endinterface

// File: rtl/mac_share_arbiter.sv
// One pipelined signed MAC shared by N_REQ burst requesters; whole bursts are granted round-robin
// and each burst returns a single tagged accumulated result.
module mac_share_arbiter #(
    parameter int N_REQ        = 4,
    parameter int A_WIDTH      = 24,
    parameter int B_WIDTH      = 24,
    parameter int ACC_WIDTH    = 56,
    parameter int MULT_LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       reset,
    mac_share_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int ML = MULT_LATENCY;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    rr_ptr, rr_ptr_n;
    logic [N_REQ-1:0] grant, grant_n;
    logic [N_REQ-1:0] ack;
    logic             first_pending, first_n;
    logic             accept;
    logic             own_req, own_last;

    logic [IW-1:0]    pick_hi, pick_lo, pick;
    logic             hi_found, lo_found;

    logic signed [A_WIDTH-1:0] a_sel;
    logic signed [B_WIDTH-1:0] b_sel;
    logic signed [PW-1:0]      prod_c;

    logic [ML-1:0]             p_valid, p_first, p_last;
    logic [IW-1:0]             p_id   [ML];
    logic signed [PW-1:0]      p_prod [ML];

    logic signed [ACC_WIDTH-1:0] prod_ext, acc, acc_next, result;
    logic [IW-1:0]               result_id;
    logic                        result_valid;

    // Round-robin pick: lowest requester above rr_ptr wins, else lowest at or below it (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_i[k]) begin
                if (IW'(k) > rr_ptr) begin
                    hi_found = 1'b1;
                    pick_hi  = IW'(k);
                end else begin
                    lo_found = 1'b1;
                    pick_lo  = IW'(k);
                end
            end
        end
        pick = hi_found ? pick_hi : pick_lo;
    end

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        a_sel    = '0;
        b_sel    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner == IW'(k)) begin
                own_req  = bus.req_i[k];
                own_last = bus.last_i[k];
                a_sel    = bus.a_i[k*A_WIDTH +: A_WIDTH];
                b_sel    = bus.b_i[k*B_WIDTH +: B_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= '0;
            grant         <= '0;
            rr_ptr        <= IW'(N_REQ - 1);
            first_pending <= 1'b0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            grant         <= grant_n;
            rr_ptr        <= rr_ptr_n;
            first_pending <= first_n;
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        grant_n  = grant;
        rr_ptr_n = rr_ptr;
        first_n  = first_pending;
        ack      = '0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (hi_found || lo_found) begin
                    owner_n       = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    first_n       = 1'b1;
                    state_n       = BURST;
                end
            end
            BURST: begin
                // A dropped owner request simply stalls; the grant is never pre-empted.
                if (own_req) begin
                    accept     = 1'b1;
                    ack[owner] = 1'b1;
                    first_n    = 1'b0;
                    if (own_last) begin
                        rr_ptr_n = owner;
                        grant_n  = '0;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign prod_c = a_sel * b_sel;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            p_valid <= '0;
            p_first <= '0;
            p_last  <= '0;
            for (int s = 0; s < ML; s++) p_id[s] <= '0;
        end else begin
            p_valid[0] <= accept;
            p_first[0] <= first_pending;
            p_last[0]  <= own_last;
            p_id[0]    <= owner;
            for (int s = 1; s < ML; s++) begin
                p_valid[s] <= p_valid[s-1];
                p_first[s] <= p_first[s-1];
                p_last[s]  <= p_last[s-1];
                p_id[s]    <= p_id[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        p_prod[0] <= prod_c;
        for (int s = 1; s < ML; s++) p_prod[s] <= p_prod[s-1];
    end

    // The first tag restarts the sum, so overlapping bursts never mix.
    assign prod_ext = ACC_WIDTH'(p_prod[ML-1]);
    assign acc_next = p_first[ML-1] ? prod_ext : acc + prod_ext;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            acc          <= '0;
            result       <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= p_valid[ML-1] & p_last[ML-1];
            if (p_valid[ML-1]) begin
                acc <= acc_next;
                if (p_last[ML-1]) begin
                    result    <= acc_next;
                    result_id <= p_id[ML-1];
                end
            end
        end
    end

    assign bus.ack_o          = ack;
    assign bus.grant_o        = grant;
    assign bus.busy_o         = (state == BURST);
    assign bus.fsm_state      = state;
    assign bus.result_o       = result;
    assign bus.result_id_o    = result_id;
    assign bus.result_valid_o = result_valid;
endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter: burst drivers push expected {id,sum} into a queue,
// a monitor pops on every result strobe; a second narrow-accumulator instance covers wrap.
module tb_mac_share_arbiter;
    localparam int N  = 4;
    localparam int AW = 24;
    localparam int CW = 56;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_share_if #(.N_REQ(N), .A_WIDTH(AW), .B_WIDTH(AW), .ACC_WIDTH(CW)) bus ();
    mac_share_if #(.N_REQ(2), .A_WIDTH(AW), .B_WIDTH(AW), .ACC_WIDTH(48)) bus2 ();

    mac_share_arbiter #(.N_REQ(N), .A_WIDTH(AW), .B_WIDTH(AW), .ACC_WIDTH(CW), .MULT_LATENCY(ML))
        dut (.clk_i(clk), .reset(reset), .bus(bus));
    mac_share_arbiter #(.N_REQ(2), .A_WIDTH(AW), .B_WIDTH(AW), .ACC_WIDTH(48), .MULT_LATENCY(ML))
        dut2 (.clk_i(clk), .reset(reset), .bus(bus2));

    logic [CW+1:0] exp_q[$];
    logic [48:0]   exp2_q[$];
    int            lat_q[$];

    logic signed [AW-1:0] ta [N][8];
    logic signed [AW-1:0] tb_v [N][8];
    int first_ack [N];
    int last_ack [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic signed [CW-1:0] value);
        exp_q.push_back({id, value});
    endtask

    task automatic set_term(input int k, input int j, input logic signed [AW-1:0] a,
                            input logic signed [AW-1:0] b);
        ta[k][j]   = a;
        tb_v[k][j] = b;
    endtask

    // Drives one burst for requester k; optionally drops req for stall_len cycles after stall_after accepts.
    task automatic send_burst(input int k, input int n, input int stall_after, input int stall_len);
        int j = 0;
        int waited = 0;
        int stalls = 0;
        logic [N-1:0] own;
        own = '0;
        own[k] = 1'b1;
        first_ack[k] = -1;
        last_ack[k] = -1;
        while (j < n) begin
            if (j == stall_after && stalls < stall_len) begin
                bus.req_i[k] = 1'b0;
                stalls++;
                @(posedge clk);
                #1;
                continue;
            end
            bus.req_i[k]          = 1'b1;
            bus.last_i[k]         = (j == n - 1);
            bus.a_i[k*AW +: AW]   = ta[k][j];
            bus.b_i[k*AW +: AW]   = tb_v[k][j];
            @(negedge clk);
            if (bus.ack_o[k]) begin
                chk($sformatf("grant_during_ack_r%0d", k), bus.grant_o, own);
                if (j == 0) first_ack[k] = cyc;
                if (j == n - 1) begin
                    last_ack[k] = cyc;
                    lat_q.push_back(cyc + ML + 1);
                end
                j++;
            end else begin
                waited++;
                if (waited > 200) begin
                    chk($sformatf("ack_timeout_r%0d", k), 0, 1);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.req_i[k]  = 1'b0;
        bus.last_i[k] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.result_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {bus.result_id_o, bus.result_o}, 0);
            end else begin
                chk("result_id_sum", {bus.result_id_o, bus.result_o}, exp_q.pop_front());
                if (lat_q.size() != 0) chk("result_latency", cyc, lat_q.pop_front());
                else chk("result_latency_missing", cyc, 0);
            end
        end
        if (bus2.result_valid_o) begin
            if (exp2_q.size() == 0) chk("unexpected_result2", {bus2.result_id_o, bus2.result_o}, 0);
            else chk("wrap_result", {bus2.result_id_o, bus2.result_o}, exp2_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int w;
        int acks;
        reset = 1'b1;
        bus.req_i = '0; bus.last_i = '0; bus.a_i = '0; bus.b_i = '0;
        bus2.req_i = '0; bus2.last_i = '0; bus2.a_i = '0; bus2.b_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", bus.ack_o, 0);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_result", bus.result_o, 0);
        chk("rst_result_id", bus.result_id_o, 0);
        chk("rst_result_valid", bus.result_valid_o, 0);
        chk("rst_state", bus.fsm_state, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single 3-term burst from requester 1: 12 - 14 - 5 = -7
        set_term(1, 0, 3, 4); set_term(1, 1, -2, 7); set_term(1, 2, 5, -1);
        push_exp(1, -7);
        t0 = cyc;
        send_burst(1, 3, -1, 0);
        chk("single_first_ack", first_ack[1], t0 + 1);
        chk("single_last_ack", last_ack[1], t0 + 3);
        repeat (6) @(posedge clk);
        #1;

        // Fresh reset so requester 0 leads, then all four contend with 2-term bursts of 1*1
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_term(k, 0, 1, 1);
            set_term(k, 1, 1, 1);
            push_exp(2'(k), 2);
        end
        t0 = cyc;
        fork
            send_burst(0, 2, -1, 0);
            send_burst(1, 2, -1, 0);
            send_burst(2, 2, -1, 0);
            send_burst(3, 2, -1, 0);
        join
        for (int k = 0; k < N; k++) begin
            chk($sformatf("contend_first_ack_r%0d", k), first_ack[k], t0 + 1 + 3 * k);
            chk($sformatf("contend_last_ack_r%0d", k), last_ack[k], t0 + 2 + 3 * k);
        end
        repeat (6) @(posedge clk);
        #1;

        // Requester 2 stalls 3 cycles mid-burst while requester 0 waits: 20+30+40+50 = 140, then -21
        for (int j = 0; j < 4; j++) set_term(2, j, AW'(2 + j), 10);
        set_term(0, 0, 7, -3);
        push_exp(2, 140);
        push_exp(0, -21);
        t0 = cyc;
        fork
            send_burst(2, 4, 2, 3);
            begin
                @(posedge clk);
                #1;
                send_burst(0, 1, -1, 0);
            end
            begin
                repeat (3) @(posedge clk);
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_no_ack", bus.ack_o, 0);
                    chk("stall_grant_held", bus.grant_o, 4'b0100);
                end
            end
        join
        chk("stall_last_ack_r2", last_ack[2], t0 + 7);
        chk("stall_first_ack_r0", first_ack[0], t0 + 9);
        repeat (6) @(posedge clk);
        #1;

        // Extremes: (-2^23)^2 = 2^46 fits in 56 bits; two of them wrap to -2^47 in 48 bits
        set_term(3, 0, 24'sh800000, 24'sh800000);
        push_exp(3, 56'sh0000400000000000);
        exp2_q.push_back({1'b0, 48'h800000000000});
        send_burst(3, 1, -1, 0);
        bus2.req_i[0] = 1'b1;
        bus2.a_i[23:0] = 24'h800000;
        bus2.b_i[23:0] = 24'h800000;
        for (int j = 0; j < 2; j++) begin
            bus2.last_i[0] = (j == 1);
            w = 0;
            @(negedge clk);
            while (!bus2.ack_o[0] && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("dut2_ack", bus2.ack_o[0], 1);
            @(posedge clk);
            #1;
        end
        bus2.req_i = '0;
        bus2.last_i = '0;
        repeat (6) @(posedge clk);
        #1;

        // Reset after 2 of 4 large terms: nothing may emerge, and the next burst starts clean
        bus.req_i[1] = 1'b1;
        bus.last_i[1] = 1'b0;
        bus.a_i[AW +: AW] = 24'sd1000;
        bus.b_i[AW +: AW] = 24'sd1000;
        acks = 0;
        w = 0;
        while (acks < 2 && w < 50) begin
            @(negedge clk);
            if (bus.ack_o[1]) acks++;
            w++;
            @(posedge clk);
            #1;
        end
        chk("midburst_acks", acks, 2);
        bus.req_i = '0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ack", bus.ack_o, 0);
        chk("midrst_grant", bus.grant_o, 0);
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_result", bus.result_o, 0);
        chk("midrst_result_id", bus.result_id_o, 0);
        chk("midrst_result_valid", bus.result_valid_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        set_term(1, 0, 3, 3);
        set_term(1, 1, 1, 1);
        push_exp(1, 10);
        t0 = cyc;
        send_burst(1, 2, -1, 0);
        chk("post_rst_first_ack", first_ack[1], t0 + 1);
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back single terms: 5*5 from requester 3 then 2*3 from requester 0, two cycles apart
        set_term(3, 0, 5, 5);
        set_term(0, 0, 2, 3);
        push_exp(3, 25);
        push_exp(0, 6);
        fork
            send_burst(3, 1, -1, 0);
            send_burst(0, 1, -1, 0);
        join
        chk("b2b_spacing", last_ack[0] - last_ack[3], 2);

        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp2_q_drained", exp2_q.size(), 0);
        chk("idle_at_end", bus.busy_o, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_share_arbiter.md
# mac_share_arbiter

Shares a single pipelined signed multiply-accumulate unit among N_REQ FIR-style requesters. It is intended for the QPD shear and pointing input filters and the delay lines, which currently each instantiate their own MAC. Requesters submit bursts of operand pairs, and the block grants whole bursts in round-robin order. Each burst's products are accumulated, and one tagged result is returned per burst.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- A_WIDTH, 24, signed sample operand width
- B_WIDTH, 24, signed coefficient operand width
- ACC_WIDTH, 56, signed accumulator/result width (≥ A_WIDTH+B_WIDTH)
- MULT_LATENCY, 2, multiplier register stages (≥1)

Ports:
- clk_i  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_i  in  N_REQ  per-requester "operand pair valid"
- last_i  in  N_REQ  per-requester "this pair is the final term of the burst"
- a_i  in  N_REQ*A_WIDTH  signed operand A; requester k on [k*A_WIDTH +: A_WIDTH]
- b_i  in  N_REQ*B_WIDTH  signed operand B; same slicing
- ack_o  out  N_REQ  one-hot; pair from requester k accepted this cycle
- grant_o  out  N_REQ  one-hot registered burst owner; 0 when idle
- busy_o  out  1  high in BURST state
- result_o  out  ACC_WIDTH  signed burst sum
- result_id_o  out  $clog2(N_REQ)  index of the requester owning result_o
- result_valid_o  out  1  one-cycle strobe for result_o/result_id_o

## Operation
The FSM has two states: IDLE and BURST.

IDLE:
- If any req_i bit is set, select the first set index searching upward (with wrap) from rr_ptr+1.
- Register that index into grant_o, set first_pending=1, and go to BURST.
- No ack is issued in IDLE.

BURST with owner g:
- ack_o[g] = req_i[g], combinational; a pair is accepted when ack_o[g]=1.
- If req_i[g]=0, the block stalls: no ack is issued and the pipeline receives nothing. The grant is held indefinitely, and no other requester can pre-empt it.
- On an accepted pair with last_i[g]=1, set rr_ptr ← g, clear grant_o, and go to IDLE.
- req_i of non-owners is ignored, never acknowledged, and never lost. Requesters hold req until acknowledged.

Pipeline:
- Each accepted pair enters with tags {first=first_pending, last=last_i[g], id=g}. first_pending clears after the first accept.
- The product is full precision A_WIDTH+B_WIDTH signed, sign-extended to ACC_WIDTH.
- Accumulate stage: acc ← first ? prod : acc + prod. Arithmetic is two's-complement wrap in ACC_WIDTH, with no saturation.
- When the accumulate stage holds a last-tagged term, the block registers result_o=new acc and result_id_o=id, and pulses result_valid_o.
- A single-term burst (first and last on the same pair) returns exactly its product.
- Bursts from different requesters may overlap in the pipeline. The first tag guarantees no cross-contamination between them.

Reset:
- All state clears: IDLE, rr_ptr=N_REQ-1 (so requester 0 has priority first), and pipeline valid/tag bits cleared.
- Outputs after reset: ack_o=0, grant_o=0, busy_o=0, result_o=0, result_id_o=0, result_valid_o=0.
- Reset mid-burst discards the partial burst, and no result is emitted for it.

## Timing
- Grant latency: req_i rises at cycle t in IDLE → grant_o/busy_o high at t+1 → first ack at t+1 if req is still high.
- Throughput: one pair per cycle within a burst.
- Burst turnaround: exactly one idle bubble cycle after the last-term ack before the next grant.
- Result latency: last pair acknowledged at cycle t → result_valid_o high at t+MULT_LATENCY+1, for exactly one cycle.
- A burst of L contiguous terms granted at cycle s produces its result at s+L-1+MULT_LATENCY+1.
- Each requester can have at most one burst outstanding through arbitration. Results appear in acceptance order.

## Test plan
- Single burst: requester 1 sends a={3,-2,5}, b={4,7,-1}, last on the third pair. Expect grant_o=0010, three consecutive acks, result_o=-7, result_id_o=1, and result_valid_o 3 cycles after the third ack (MULT_LATENCY=2).
- Contention: req_i=1111 simultaneously, each sending a 2-term burst of all-ones products. Expect grant order 0,1,2,3, one bubble between bursts, and four results each =2 with ids 0..3 in order.
- Stall: requester 2 drops req for 3 cycles mid-burst while requester 0 requests. Expect grant held on 2, no acks to 0, the accumulator unaffected, and the correct sum afterwards; requester 0 is granted after 2's last term.
- Single-term and extremes: a=-2^23, b=-2^23, last=1. Expect result_o=2^46 and no wrap at ACC_WIDTH=56. With ACC_WIDTH=48, a 2-term burst of that pair gives 2^47, which wraps to -2^47.
- Reset mid-burst: assert reset after 2 of 4 terms. Expect no result_valid_o, all outputs 0 the next cycle, and a fresh burst afterwards whose sum is uncontaminated.
- Back-to-back overlap: requester 3 sends a 1-term burst (5×5) immediately followed by requester 0 sending a 1-term burst (2×3). Expect results 25 (id 3) then 6 (id 0), two cycles apart.
